// File: rtl/axi_slave_mem.sv
// axi_slave_mem: single-beat AXI slave memory with independent write and read channels.
// Define AXI_SLAVE_MEM_WSTRB_EN to honour WSTRB byte strobes; otherwise every good write stores the full word.
module axi_slave_mem #(
    parameter int ID_W      = 4,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [ID_W-1:0]     AWID,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [ID_W-1:0]     ARID,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST
);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic [25:0]         aw_idx_q;
    logic [ID_W-1:0]     aw_id_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic                w_last_q;
    logic                aw_held, w_held;

    logic                aw_fire, w_fire, have_aw, have_w, commit, w_ok, wr_en;
    logic [25:0]         cur_idx;
    logic [ID_W-1:0]     cur_id;
    logic [DATA_W-1:0]   cur_data, wr_word, rd_word;
    logic [DATA_W/8-1:0] cur_strb;
    logic                cur_last;
    logic                ar_fire, ar_ok;
    logic [25:0]         ar_idx;
    logic                unused_bits;

    // AW and W may arrive in either order; the live beat overrides the held copy.
    assign aw_fire  = AWVALID && AWREADY;
    assign w_fire   = WVALID && WREADY;
    assign have_aw  = aw_held || aw_fire;
    assign have_w   = w_held || w_fire;
    assign cur_idx  = aw_fire ? AWADDR[27:2] : aw_idx_q;
    assign cur_id   = aw_fire ? AWID : aw_id_q;
    assign cur_data = w_fire ? WDATA : w_data_q;
    assign cur_strb = w_fire ? WSTRB : w_strb_q;
    assign cur_last = w_fire ? WLAST : w_last_q;
    assign commit   = (w_state == W_IDLE) && have_aw && have_w;
    assign w_ok     = cur_last && ((cur_idx >> IW) == '0);
    assign wr_en    = commit && w_ok;
    assign ar_fire  = ARVALID && ARREADY;
    assign ar_idx   = ARADDR[27:2];
    assign ar_ok    = (ar_idx >> IW) == '0;
    assign unused_bits = ^{AWADDR[ADDR_W-1:28], AWADDR[1:0], ARADDR[ADDR_W-1:28], ARADDR[1:0], cur_strb};

    always_comb begin
        wr_word = cur_data;
`ifdef AXI_SLAVE_MEM_WSTRB_EN
        for (int i = 0; i < DATA_W/8; i++)
            wr_word[8*i +: 8] = cur_strb[i] ? cur_data[8*i +: 8] : mem[cur_idx[IW-1:0]][8*i +: 8];
`endif
    end

    // Write-first forwarding when a commit and a read capture hit the same word.
    assign rd_word = !ar_ok ? '0 : (wr_en && cur_idx == ar_idx) ? wr_word : mem[ar_idx[IW-1:0]];

    always_ff @(posedge ACLK)
        if (wr_en) mem[cur_idx[IW-1:0]] <= wr_word;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state  <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= '0;
            BRESP    <= 2'b00;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            aw_id_q  <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            w_last_q <= 1'b0;
        end else if (w_state == W_IDLE) begin
            if (aw_fire) begin
                aw_idx_q <= AWADDR[27:2];
                aw_id_q  <= AWID;
            end
            if (w_fire) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
                w_last_q <= WLAST;
            end
            if (commit) begin
                w_state <= W_RESP;
                BVALID  <= 1'b1;
                BID     <= cur_id;
                BRESP   <= w_ok ? 2'b00 : 2'b10;
                AWREADY <= 1'b0;
                WREADY  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                aw_held <= have_aw;
                w_held  <= have_w;
                AWREADY <= !have_aw;
                WREADY  <= !have_w;
            end
        end else if (BREADY) begin
            w_state <= W_IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            RLAST   <= 1'b0;
        end else if (r_state == R_IDLE) begin
            if (ar_fire) begin
                r_state <= R_RESP;
                ARREADY <= 1'b0;
                RVALID  <= 1'b1;
                RLAST   <= 1'b1;
                RID     <= ARID;
                RDATA   <= rd_word;
                RRESP   <= ar_ok ? 2'b00 : 2'b10;
            end else begin
                ARREADY <= 1'b1;
            end
        end else if (RREADY) begin
            r_state <= R_IDLE;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
        end
    end
endmodule
